// File: rtl/freq_meter.sv
// Half-period meter: counts clk cycles between edges of an asynchronous square wave.
// Optional lock detector compiled in with FREQ_METER_LOCK_EN.
module freq_meter #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sig_in,
    output logic [N-1:0] half_period,
    output logic         valid,
    output logic         overflow,
    output logic         busy,
    output logic         locked
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);
    localparam logic [N-1:0] TOL     = N'(LOCK_TOL);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   edge_det;

    state_t         state_q;
    logic [N-1:0]   cnt_q;
    logic [N-1:0]   hp_q;
    logic           valid_q;
    logic           ovf_q;
    logic           busy_q;
    logic           res_evt;
    logic           ovf_evt;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Both polarities of the synchronised input mark an interval boundary
    assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

    assign res_evt = en && (state_q == MEASURE) && edge_det;
    assign ovf_evt = en && (state_q == MEASURE) && !edge_det
                     && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hp_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                    ARM: begin
                        if (edge_det) begin
                            state_q <= MEASURE;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (edge_det) begin
                            hp_q    <= cnt_q;
                            valid_q <= 1'b1;
                            ovf_q   <= 1'b0;
                            cnt_q   <= CNT_ONE;
                        end else if (cnt_q == CNT_MAX) begin
                            ovf_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ARM;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign half_period = hp_q;
    assign valid       = valid_q;
    assign overflow    = ovf_q;
    assign busy        = busy_q;

`ifdef FREQ_METER_LOCK_EN
    logic [N-1:0] prev_q;
    logic         has_prev_q;
    logic         locked_q;
    logic [N-1:0] diff;

    assign diff = (cnt_q > prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            has_prev_q <= 1'b0;
            locked_q   <= 1'b0;
        end else if (!en) begin
            has_prev_q <= 1'b0;
            locked_q   <= 1'b0;
        end else if (res_evt) begin
            locked_q   <= has_prev_q && (diff <= TOL);
            prev_q     <= cnt_q;
            has_prev_q <= 1'b1;
        end else if (ovf_evt) begin
            // a timed-out interval breaks the chain of comparable results
            has_prev_q <= 1'b0;
            locked_q   <= 1'b0;
        end
    end

    assign locked = locked_q;
`else
    logic unused_lock;
    assign unused_lock = res_evt ^ ovf_evt ^ (^TOL);
    assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: timestamp-based reference model plus directed vectors.
// Build with +define+FREQ_METER_LOCK_EN to exercise the lock detector.
module tb_freq_meter;

    localparam int N    = 8;
    localparam int S    = 2;
    localparam int TOL  = 2;
    localparam int MAXC = (1 << N) - 1;

    logic         clk;
    logic         rst;
    logic         en;
    logic         sig_in;
    logic [N-1:0] half_period;
    logic         valid;
    logic         overflow;
    logic         busy;
    logic         locked;

    int n_cmp;
    int n_bad;

    freq_meter #(.N(N), .SYNC_STAGES(S), .LOCK_TOL(TOL)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sig_in(sig_in),
        .half_period(half_period),
        .valid(valid),
        .overflow(overflow),
        .busy(busy),
        .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges are timestamped, results are timestamp differences
    logic sh[$];
    int   cyc;
    int   m_mode;
    int   m_last;
    int   m_hp;
    int   m_prev;
    int   d;
    bit   m_val;
    bit   m_ovf;
    bit   m_lock;
    bit   m_hasp;
    bit   e;
    bit   exp_lock;

    initial begin
        for (int i = 0; i < 8; i++) sh.push_front(1'b0);
        cyc = 0; m_mode = 0; m_last = 0; m_hp = 0; m_prev = 0;
        m_val = 0; m_ovf = 0; m_lock = 0; m_hasp = 0;
    end

    always @(posedge clk) begin
        cyc++;
        sh.push_front(rst ? 1'b0 : sig_in);
        void'(sh.pop_back());
        e = sh[S] ^ sh[S+1];
        if (rst) begin
            m_mode = 0; m_hp = 0; m_val = 0; m_ovf = 0;
            m_lock = 0; m_hasp = 0;
        end else begin
            m_val = 0;
            if (!en) begin
                m_mode = 0; m_ovf = 0; m_lock = 0; m_hasp = 0;
            end else begin
                case (m_mode)
                    0: m_mode = 1;
                    1: if (e) begin m_mode = 2; m_last = cyc; end
                    default: begin
                        if (e) begin
                            m_val = 1;
                            m_hp = cyc - m_last;
                            m_ovf = 0;
                            m_last = cyc;
                            d = (m_hp > m_prev) ? m_hp - m_prev : m_prev - m_hp;
                            m_lock = m_hasp && (d <= TOL);
                            m_prev = m_hp;
                            m_hasp = 1;
                        end else if (cyc - m_last == MAXC) begin
                            m_ovf = 1; m_mode = 1; m_lock = 0; m_hasp = 0;
                        end
                    end
                endcase
            end
        end
`ifdef FREQ_METER_LOCK_EN
        exp_lock = m_lock;
`else
        exp_lock = 1'b0;
`endif
        #1;
        chk("valid", {31'b0, valid}, {31'b0, m_val});
        chk("half_period", {24'b0, half_period}, m_hp);
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("busy", {31'b0, busy}, {31'b0, m_mode != 0});
        chk("locked", {31'b0, locked}, {31'b0, exp_lock});
    end

    task automatic toggle(input int p, input int n);
        repeat (n) begin
            repeat (p) @(negedge clk);
            sig_in = ~sig_in;
        end
    endtask

    task automatic lk(input int p, input int exp_hp, input logic exp_l);
        repeat (p - 4) @(negedge clk);
        sig_in = ~sig_in;
        repeat (4) @(negedge clk);
        chk("lock_hp", {24'b0, half_period}, exp_hp);
`ifdef FREQ_METER_LOCK_EN
        chk("lock_seq", {31'b0, locked}, {31'b0, exp_l});
`else
        chk("lock_off", {31'b0, locked}, {31'b0, exp_l & 1'b0});
`endif
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; en = 1'b0; sig_in = 1'b0;
        #1;
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_hp", {24'b0, half_period}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;

        // Steady wave: first interval discarded, then 200 each time
        toggle(200, 4);
        repeat (4) @(negedge clk);
        chk("hp_200", {24'b0, half_period}, 200);
        chk("ovf_200", {31'b0, overflow}, 0);

        // Edge every cycle
        toggle(1, 6);
        repeat (2) @(negedge clk);
        chk("valid_every", {31'b0, valid}, 1);
        toggle(1, 4);
        repeat (4) @(negedge clk);
        chk("hp_1", {24'b0, half_period}, 1);

        // Static input saturates the counter
        repeat (300) @(negedge clk);
        chk("ovf_set", {31'b0, overflow}, 1);
        chk("ovf_busy", {31'b0, busy}, 1);
        toggle(10, 3);
        repeat (4) @(negedge clk);
        chk("hp_10", {24'b0, half_period}, 10);
        chk("ovf_clr", {31'b0, overflow}, 0);

        // Edge coinciding with saturation is a result, not an overflow
        toggle(251, 1);
        repeat (4) @(negedge clk);
        chk("hp_max", {24'b0, half_period}, 255);
        chk("ovf_max", {31'b0, overflow}, 0);

        // Enable dropped mid-interval
        repeat (7) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("dis_busy", {31'b0, busy}, 0);
        chk("dis_valid", {31'b0, valid}, 0);
        chk("dis_hp", {24'b0, half_period}, 255);
        repeat (2) @(negedge clk);
        en = 1'b1;
        toggle(20, 3);
        repeat (4) @(negedge clk);
        chk("hp_20", {24'b0, half_period}, 20);

        // Lock sequence after a fresh arm
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        toggle(10, 1);
        repeat (4) @(negedge clk);
        lk(100, 100, 1'b0);
        lk(100, 100, 1'b1);
        lk(101, 101, 1'b1);
        lk(104, 104, 1'b0);

        // Asynchronous reset in the middle of an interval
        repeat (30) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_hp", {24'b0, half_period}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_ovf", {31'b0, overflow}, 0);
        chk("arst_valid", {31'b0, valid}, 0);
        chk("arst_lock", {31'b0, locked}, 0);
        @(negedge clk);
        rst = 1'b0;
        toggle(30, 3);
        repeat (4) @(negedge clk);
        chk("hp_30", {24'b0, half_period}, 30);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
